// File: rtl/param_asmd_counter.sv
// -----------------------------------------------------------------------------
// param_asmd_counter
//   Start-triggered up/down counter with a tracked-bit flag and a completion
//   flag. A run loads A from init_val and counts in the sampled direction. The
//   run ends after the cycle whose pre-update A has every STOP_MASK bit set, or
//   when abort is seen. A one-cycle DONE state then raises F.
//
// Parameters
//   WIDTH     : width of counter A (>= 2)
//   E_BIT     : index of the A bit copied into E (0..WIDTH-1)
//   STOP_MASK : bits that must all be 1 in pre-update A to end a run
//
// Ports
//   clk      in   clock, rising edge
//   rstb     in   asynchronous active-low reset
//   start    in   begin a run (honoured in IDLE only)
//   init_val in   start value of A, loaded on an accepted start
//   dir      in   0 = count up, 1 = count down, sampled on an accepted start
//   abort    in   terminate the current run (honoured in COUNT only)
//   A        out  counter value (registered)
//   E        out  tracked-bit flag (registered)
//   F        out  run-completed flag (registered)
//   busy     out  state is COUNT (decode of the state register)
//   done     out  state is DONE (decode of the state register)
//   state    out  state register: IDLE=00, COUNT=01, DONE=10
// -----------------------------------------------------------------------------
module param_asmd_counter #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      E_BIT     = 2,
    parameter logic [WIDTH-1:0] STOP_MASK = WIDTH'(4'b1100)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic [WIDTH-1:0] init_val,
    input  logic             dir,
    input  logic             abort,
    output logic [WIDTH-1:0] A,
    output logic             E,
    output logic             F,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("param_asmd_counter: WIDTH must be >= 2");
    end
    if (E_BIT >= WIDTH) begin : g_bad_ebit
        $error("param_asmd_counter: E_BIT must be below WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_DONE  = 2'b10,
        S_ILL   = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_nxt;

    logic             dir_q;
    logic [WIDTH-1:0] a_nxt;
    logic             e_nxt;
    logic             f_nxt;
    logic             dir_nxt;

    // Stop condition is evaluated on the value A holds before this cycle's update.
    logic             stop_hit;
    assign stop_hit = ((A & STOP_MASK) == STOP_MASK);

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; abort outranks the stop check in COUNT.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (stop_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output/datapath next values and state decodes; unlisted fields hold.
    always_comb begin
        a_nxt   = A;
        e_nxt   = E;
        f_nxt   = F;
        dir_nxt = dir_q;
        busy    = (state_q == S_COUNT);
        done    = (state_q == S_DONE);
        state   = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_nxt   = init_val;
                    f_nxt   = 1'b0;
                    dir_nxt = dir;
                end
            end
            S_COUNT: begin
                if (!abort) begin
                    a_nxt = dir_q ? (A - WIDTH'(1)) : (A + WIDTH'(1));
                    e_nxt = A[E_BIT];
                end
            end
            S_DONE: begin
                f_nxt = 1'b1;
            end
            default: begin
                // Illegal encoding: recover to IDLE with no datapath action.
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            A     <= '0;
            E     <= 1'b0;
            F     <= 1'b0;
            dir_q <= 1'b0;
        end else begin
            A     <= a_nxt;
            E     <= e_nxt;
            F     <= f_nxt;
            dir_q <= dir_nxt;
        end
    end

endmodule
